// File: rtl/perip_bus_arbiter_pkg.sv
// Shared constants for the peripheral bus: bus geometry, slave indices and arbiter states.
package perip_bus_arbiter_pkg;

    localparam int          DATA_W     = 32;
    localparam logic [31:0] PERIP_BASE = 32'hA000_0000;
    localparam int          SEL_LO     = 12;

    localparam logic [1:0] SLV_KBD   = 2'd0;
    localparam logic [1:0] SLV_VGA   = 2'd1;
    localparam logic [1:0] SLV_TIMER = 2'd2;
    localparam logic [1:0] SLV_UART  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_e;

endpackage

// File: rtl/perip_bus_arbiter_addr_decode.sv
// Address to slave decode: window hit on the upper half-word, 2-bit slave select inside the window.
module perip_addr_decode
    import perip_bus_arbiter_pkg::*;
#(
    parameter int                DATA_W     = perip_bus_arbiter_pkg::DATA_W,
    parameter logic [DATA_W-1:0] PERIP_BASE = perip_bus_arbiter_pkg::PERIP_BASE,
    parameter int                SEL_LO     = perip_bus_arbiter_pkg::SEL_LO
) (
    input  logic [DATA_W-1:0] addr_i,
    output logic              hit_o,
    output logic [1:0]        sel_o
);

    logic unused_addr;

    assign hit_o = (addr_i[DATA_W-1:16] == PERIP_BASE[DATA_W-1:16]);
    assign sel_o = addr_i[SEL_LO+1:SEL_LO];

    // Offset bits inside a slave's 4 KiB page are the slave's own business.
    assign unused_addr = ^{addr_i[15:SEL_LO+2], addr_i[SEL_LO-1:0]};

endmodule

// File: rtl/perip_bus_arbiter.sv
// Two-master round-robin arbiter for the peripheral bus; one single-cycle slave enable per access.
module perip_bus_arbiter
    import perip_bus_arbiter_pkg::*;
#(
    parameter int                DATA_W     = perip_bus_arbiter_pkg::DATA_W,
    parameter logic [DATA_W-1:0] PERIP_BASE = perip_bus_arbiter_pkg::PERIP_BASE,
    parameter int                SEL_LO     = perip_bus_arbiter_pkg::SEL_LO
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          m_req_i,
    input  logic [1:0]          m_rw_i,
    input  logic [2*DATA_W-1:0] m_addr_i,
    input  logic [2*DATA_W-1:0] m_wdata_i,
    output logic [1:0]          m_gnt_o,
    output logic [1:0]          m_done_o,
    output logic [1:0]          m_err_o,
    output logic [2*DATA_W-1:0] m_rdata_o,
    output logic [3:0]          s_ena_o,
    output logic                s_rw_o,
    output logic [DATA_W-1:0]   s_addr_o,
    output logic [DATA_W-1:0]   s_wdata_o,
    input  logic [4*DATA_W-1:0] s_rdata_i
);

    arb_state_e          state_q, state_d;
    logic                win;
    logic [DATA_W-1:0]   win_addr;
    logic                win_hit;
    logic [1:0]          win_sel;

    logic                win_q;
    logic                rr_last_q;
    logic                rw_q;
    logic [DATA_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                hit_q;
    logic [1:0]          sel_q;
    logic [1:0]          done_q;
    logic [1:0]          err_q;
    logic [2*DATA_W-1:0] rdata_q;

    // On a tie the master that did not win last time goes first.
    assign win      = (m_req_i == 2'b11) ? ~rr_last_q : ~m_req_i[0];
    assign win_addr = m_addr_i[win*DATA_W +: DATA_W];

    perip_addr_decode #(
        .DATA_W     (DATA_W),
        .PERIP_BASE (PERIP_BASE),
        .SEL_LO     (SEL_LO)
    ) u_decode (
        .addr_i (win_addr),
        .hit_o  (win_hit),
        .sel_o  (win_sel)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (|m_req_i) state_d = ST_ACCESS;
            ST_ACCESS: state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        m_gnt_o = '0;
        s_ena_o = '0;
        if (state_q == ST_IDLE && |m_req_i) begin
            m_gnt_o[win] = 1'b1;
        end
        if (state_q == ST_ACCESS && hit_q) begin
            s_ena_o[sel_q] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            win_q     <= 1'b0;
            rr_last_q <= 1'b1;
            rw_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            hit_q     <= 1'b0;
            sel_q     <= '0;
            done_q    <= '0;
            err_q     <= '0;
            rdata_q   <= '0;
        end else begin
            done_q <= '0;
            err_q  <= '0;
            if (state_q == ST_IDLE && |m_req_i) begin
                win_q     <= win;
                rr_last_q <= win;
                rw_q      <= m_rw_i[win];
                addr_q    <= win_addr;
                wdata_q   <= m_wdata_i[win*DATA_W +: DATA_W];
                hit_q     <= win_hit;
                sel_q     <= win_sel;
            end
            // Writes and misses return zero so stale slave data never leaks to a master.
            if (state_q == ST_RESP) begin
                done_q[win_q] <= 1'b1;
                err_q[win_q]  <= ~hit_q;
                rdata_q[win_q*DATA_W +: DATA_W] <= (!rw_q && hit_q) ?
                    s_rdata_i[sel_q*DATA_W +: DATA_W] : '0;
            end
        end
    end

    assign m_done_o  = done_q;
    assign m_err_o   = err_q;
    assign m_rdata_o = rdata_q;
    assign s_rw_o    = rw_q;
    assign s_addr_o  = addr_q;
    assign s_wdata_o = wdata_q;

endmodule

// File: tb/tb_perip_bus_arbiter.sv
// Scoreboard bench for perip_bus_arbiter with simple slave models that drive data only after ena.
module tb_perip_bus_arbiter;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [1:0]   m_req = '0;
    logic [1:0]   m_rw = '0;
    logic [63:0]  m_addr = '0;
    logic [63:0]  m_wdata = '0;
    logic [1:0]   m_gnt;
    logic [1:0]   m_done;
    logic [1:0]   m_err;
    logic [63:0]  m_rdata;
    logic [3:0]   s_ena;
    logic         s_rw;
    logic [31:0]  s_addr;
    logic [31:0]  s_wdata;
    logic [127:0] s_rdata = '0;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [31:0] slave_val [4];
    int          rd_cnt [4];

    typedef struct { int m; logic [31:0] rdata; logic err; int due; } dexp_t;
    typedef struct { logic [3:0] ena; int due; } eexp_t;
    dexp_t       dq[$];
    eexp_t       eq[$];
    int          glog[$];
    logic [31:0] exp_rd [2];

    perip_bus_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .m_req_i   (m_req),
        .m_rw_i    (m_rw),
        .m_addr_i  (m_addr),
        .m_wdata_i (m_wdata),
        .m_gnt_o   (m_gnt),
        .m_done_o  (m_done),
        .m_err_o   (m_err),
        .m_rdata_o (m_rdata),
        .s_ena_o   (s_ena),
        .s_rw_o    (s_rw),
        .s_addr_o  (s_addr),
        .s_wdata_o (s_wdata),
        .s_rdata_i (s_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        for (int k = 0; k < 4; k++) begin
            slave_val[k] = 32'h0;
            rd_cnt[k]    = 0;
        end
        exp_rd[0] = 32'h0;
        exp_rd[1] = 32'h0;
    end

    // Slave models: data is only meaningful the cycle after ena; otherwise a poison pattern.
    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (s_ena[k] && !s_rw) begin
                s_rdata[k*32 +: 32] <= slave_val[k];
                rd_cnt[k] <= rd_cnt[k] + 1;
            end else begin
                s_rdata[k*32 +: 32] <= 32'hDEAD_BE00 + 32'(k);
            end
        end
    end

    always @(negedge clk) begin : monitor
        logic [31:0] a;
        int          w;
        logic        hit;
        logic [1:0]  sel;
        dexp_t       d;
        eexp_t       e;

        checks++;
        if ($countones(s_ena) > 1) begin
            errors++;
            $display("FAIL onehot_ena: s_ena=%b, required at most one bit", s_ena);
        end

        if (eq.size() > 0 && eq[0].due == cyc) begin
            e = eq.pop_front();
            checks++;
            if (s_ena !== e.ena) begin
                errors++;
                $display("FAIL ena_pulse: cyc=%0d s_ena=%b, required %b", cyc, s_ena, e.ena);
            end
        end else if (s_ena !== 4'b0000) begin
            checks++;
            errors++;
            $display("FAIL stray_ena: cyc=%0d s_ena=%b, required 0000", cyc, s_ena);
        end

        if (m_done !== 2'b00) begin
            checks++;
            if (dq.size() == 0) begin
                errors++;
                $display("FAIL stray_done: cyc=%0d m_done=%b, required 00", cyc, m_done);
            end else begin
                d = dq.pop_front();
                exp_rd[d.m] = d.rdata;
                if (m_done !== (2'b01 << d.m) || m_err !== ({1'b0, d.err} << d.m) ||
                    m_rdata !== {exp_rd[1], exp_rd[0]} || cyc != d.due) begin
                    errors++;
                    $display("FAIL sb_done: cyc=%0d done=%b err=%b rdata=%h, required cyc=%0d done=%b err=%b rdata=%h",
                             cyc, m_done, m_err, m_rdata, d.due, 2'b01 << d.m,
                             {1'b0, d.err} << d.m, {exp_rd[1], exp_rd[0]});
                end
            end
        end else if (m_err !== 2'b00) begin
            checks++;
            errors++;
            $display("FAIL stray_err: cyc=%0d m_err=%b, required 00", cyc, m_err);
        end

        if (rst) begin
            dq.delete();
            eq.delete();
            exp_rd[0] = 32'h0;
            exp_rd[1] = 32'h0;
        end else if (m_gnt !== 2'b00) begin
            w   = m_gnt[1] ? 1 : 0;
            glog.push_back(w);
            a   = m_addr[w*32 +: 32];
            hit = (a[31:16] == 16'hA000);
            sel = a[13:12];
            d.m     = w;
            d.err   = !hit;
            d.rdata = (hit && !m_rw[w]) ? slave_val[sel] : 32'h0;
            d.due   = cyc + 3;
            dq.push_back(d);
            e.ena = hit ? (4'b0001 << sel) : 4'b0000;
            e.due = cyc + 1;
            eq.push_back(e);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        m_req = 2'b00;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_gnt(input int mi, output int t);
        t = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m_gnt[mi]) begin
                t = cyc;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL gnt_timeout: master %0d got no grant, required one within 20 cycles", mi);
    endtask

    task automatic wait_done(input int mi, output int t);
        t = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m_done[mi]) begin
                t = cyc;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL done_timeout: master %0d got no done, required one within 20 cycles", mi);
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if (m_gnt !== 2'b00 || s_ena !== 4'b0 || m_done !== 2'b00 || m_err !== 2'b00) begin
            errors++;
            $display("FAIL reset_ctrl: gnt=%b ena=%b done=%b err=%b, required all zero", m_gnt, s_ena, m_done, m_err);
        end
        checks++;
        if (s_rw !== 1'b0 || s_addr !== 32'h0 || s_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_slave: rw=%b addr=%h wdata=%h, required zero", s_rw, s_addr, s_wdata);
        end
        checks++;
        if (m_rdata !== 64'h0) begin
            errors++;
            $display("FAIL reset_rdata: m_rdata=%h, required 0", m_rdata);
        end
    endtask

    task automatic test_single_read();
        int t0, t1;
        slave_val[0] = 32'h8000_001C;
        tick();
        m_req = 2'b01;
        m_rw  = 2'b00;
        m_addr[31:0] = 32'hA000_0000;
        wait_gnt(0, t0);
        tick();
        m_req = 2'b00;
        @(negedge clk);
        checks++;
        if (s_ena !== 4'b0001 || cyc != t0 + 1) begin
            errors++;
            $display("FAIL read_ena: s_ena=%b at cyc %0d, required 0001 at cyc %0d", s_ena, cyc, t0 + 1);
        end
        wait_done(0, t1);
        checks++;
        if (t1 != t0 + 3 || m_rdata[31:0] !== 32'h8000_001C || m_err !== 2'b00) begin
            errors++;
            $display("FAIL read_done: cyc=%0d rdata=%h err=%b, required cyc=%0d rdata=8000001c err=00",
                     t1, m_rdata[31:0], m_err, t0 + 3);
        end
    endtask

    task automatic test_write();
        int t0, t1;
        tick();
        m_req = 2'b10;
        m_rw  = 2'b10;
        m_addr[63:32]  = 32'hA000_2004;
        m_wdata[63:32] = 32'h1234_5678;
        wait_gnt(1, t0);
        tick();
        m_req = 2'b00;
        @(negedge clk);
        checks++;
        if (s_ena !== 4'b0100 || s_rw !== 1'b1 || s_wdata !== 32'h1234_5678 || s_addr !== 32'hA000_2004) begin
            errors++;
            $display("FAIL write_access: ena=%b rw=%b addr=%h wdata=%h, required 0100 1 a0002004 12345678",
                     s_ena, s_rw, s_addr, s_wdata);
        end
        wait_done(1, t1);
        checks++;
        if (t1 != t0 + 3 || m_rdata[63:32] !== 32'h0 || m_err !== 2'b00) begin
            errors++;
            $display("FAIL write_done: cyc=%0d rdata1=%h err=%b, required cyc=%0d rdata1=0 err=00",
                     t1, m_rdata[63:32], m_err, t0 + 3);
        end
        checks++;
        if (m_rdata[31:0] !== 32'h8000_001C) begin
            errors++;
            $display("FAIL other_rdata: rdata0=%h, required 8000001c unchanged", m_rdata[31:0]);
        end
    endtask

    task automatic test_miss();
        int t0, t1;
        tick();
        m_req = 2'b01;
        m_rw  = 2'b00;
        m_addr[31:0] = 32'h8000_0000;
        wait_gnt(0, t0);
        tick();
        m_req = 2'b00;
        @(negedge clk);
        checks++;
        if (s_ena !== 4'b0000) begin
            errors++;
            $display("FAIL miss_ena: s_ena=%b, required 0000", s_ena);
        end
        wait_done(0, t1);
        checks++;
        if (t1 != t0 + 3 || m_done !== 2'b01 || m_err !== 2'b01 || m_rdata[31:0] !== 32'h0) begin
            errors++;
            $display("FAIL miss_done: cyc=%0d done=%b err=%b rdata=%h, required cyc=%0d done=01 err=01 rdata=0",
                     t1, m_done, m_err, m_rdata[31:0], t0 + 3);
        end
    endtask

    task automatic test_fairness();
        int n0, c0, c2;
        bit got;
        do_reset();
        n0 = glog.size();
        c0 = rd_cnt[0];
        c2 = rd_cnt[2];
        slave_val[0] = 32'h1111_0000;
        slave_val[2] = 32'h2222_0002;
        tick();
        m_req  = 2'b11;
        m_rw   = 2'b00;
        m_addr = {32'hA000_2000, 32'hA000_0000};
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = (glog.size() >= n0 + 4);
        end
        tick();
        m_req = 2'b00;
        repeat (4) @(negedge clk);
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL rr_timeout: grants=%0d, required 4", glog.size() - n0);
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (i > 0) checks++;
                if (glog[n0 + i] != i % 2) begin
                    errors++;
                    $display("FAIL rr_order: grant %0d went to M%0d, required M%0d", i, glog[n0 + i], i % 2);
                end
            end
        end
        checks++;
        if (rd_cnt[0] - c0 != 2 || rd_cnt[2] - c2 != 2) begin
            errors++;
            $display("FAIL rr_reads: kbd=%0d timer=%0d, required 2 and 2", rd_cnt[0] - c0, rd_cnt[2] - c2);
        end
    endtask

    task automatic test_reset_mid();
        int t0;
        bit seen_done;
        tick();
        m_req = 2'b01;
        m_rw  = 2'b00;
        m_addr[31:0] = 32'hA000_0000;
        wait_gnt(0, t0);
        tick();
        rst   = 1'b1;
        m_req = 2'b00;
        @(negedge clk);
        checks++;
        if (s_ena !== 4'b0001) begin
            errors++;
            $display("FAIL mid_access: s_ena=%b, required 0001", s_ena);
        end
        @(negedge clk);
        checks++;
        if (s_ena !== 4'b0000 || m_done !== 2'b00) begin
            errors++;
            $display("FAIL mid_abort: s_ena=%b done=%b, required 0000 and 00", s_ena, m_done);
        end
        tick();
        rst = 1'b0;
        seen_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (m_done !== 2'b00) seen_done = 1'b1;
        end
        checks++;
        if (seen_done) begin
            errors++;
            $display("FAIL mid_nodone: m_done pulsed after reset, required none");
        end
        tick();
        m_req  = 2'b11;
        m_rw   = 2'b00;
        m_addr = {32'hA000_0000, 32'hA000_0000};
        @(negedge clk);
        checks++;
        if (m_gnt !== 2'b01) begin
            errors++;
            $display("FAIL mid_tie: m_gnt=%b, required 01", m_gnt);
        end
        tick();
        m_req = 2'b00;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int t0, t1, t2;
        slave_val[0] = 32'hAAAA_0001;
        slave_val[3] = 32'h5555_0003;
        tick();
        m_req = 2'b01;
        m_rw  = 2'b00;
        m_addr[31:0] = 32'hA000_0000;
        wait_gnt(0, t0);
        tick();
        m_addr[31:0] = 32'hA000_3010;
        wait_gnt(0, t1);
        checks++;
        if (t1 != t0 + 3 || m_done !== 2'b01 || m_rdata[31:0] !== 32'hAAAA_0001) begin
            errors++;
            $display("FAIL b2b_overlap: gnt cyc=%0d done=%b rdata=%h, required cyc=%0d done=01 rdata=aaaa0001",
                     t1, m_done, m_rdata[31:0], t0 + 3);
        end
        tick();
        m_req = 2'b00;
        wait_done(0, t2);
        checks++;
        if (t2 != t1 + 3 || m_rdata[31:0] !== 32'h5555_0003) begin
            errors++;
            $display("FAIL b2b_second: cyc=%0d rdata=%h, required cyc=%0d rdata=55550003",
                     t2, m_rdata[31:0], t1 + 3);
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_write();
        test_miss();
        test_fairness();
        test_reset_mid();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
